dsp_mem_dump: RTL and testbench

- Read-out engine for the DSP data memory, the counterpart of the bench-side memory preload.
- On a start pulse it reads a contiguous window of data memory through a synchronous read port.
- Each 16-bit word is serialised as framed bytes on a valid/ready byte stream, for a host or bench to capture after a program run.
- Sits beside the dsp data memory on a second read port; it never writes memory.

---
 rtl/dsp_dump_pkg.sv | 19 +
 rtl/dsp_byte_tx_reg.sv | 30 +++
 rtl/dsp_mem_dump.sv | 172 +++++++++++++++++
 tb/tb_dsp_mem_dump.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dsp_dump_pkg.sv
// Shared types and constants for the DSP data-memory dump engine.
package dsp_dump_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] HDR_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_CNT,
    S_RD,
    S_CAP,
    S_HI,
    S_LO,
    S_SUM,
    S_FIN
  } state_t;

endpackage

// File: rtl/dsp_byte_tx_reg.sv
// One-entry valid/ready byte register; holds data and valid stable until the sink accepts.
module dsp_byte_tx_reg
  import dsp_dump_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              tx_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              accept_c
);

  assign accept_c = tx_valid & tx_ready;

  // A load may coincide with the accept of the previous byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      tx_data  <= load_data;
      tx_valid <= 1'b1;
    end else if (accept_c) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dsp_mem_dump.sv
// Reads a window of DSP data memory and streams it as a framed, checksummed byte sequence.
module dsp_mem_dump
  import dsp_dump_pkg::*;
#(
  parameter int unsigned       ADDR_WIDTH = 8,
  parameter int unsigned       DATA_WIDTH = 16,
  parameter logic [BYTE_W-1:0] HDR_BYTE   = HDR_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [BYTE_W-1:0]     tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic [BYTE_W-1:0]     checksum
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   rem_q, rem_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [BYTE_W-1:0]       csum_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_d;
  logic                    rd_en_d, busy_d, done_d;
  logic                    tx_load;
  logic [BYTE_W-1:0]       tx_byte;
  logic                    accept_c;

  dsp_byte_tx_reg u_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (tx_load),
    .load_data (tx_byte),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .accept_c  (accept_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      checksum  <= '0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      checksum  <= csum_d;
      mem_addr  <= mem_addr_d;
      mem_rd_en <= rd_en_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state logic; the next byte is loaded on the edge the current one transfers.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    csum_d     = checksum;
    mem_addr_d = mem_addr;
    rd_en_d    = 1'b0;
    busy_d     = busy;
    done_d     = 1'b0;
    tx_load    = 1'b0;
    tx_byte    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = word_count;
          cnt_d   = word_count;
          csum_d  = '0;
          busy_d  = 1'b1;
          tx_load = 1'b1;
          tx_byte = HDR_BYTE;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (accept_c) begin
          tx_load = 1'b1;
          tx_byte = BYTE_W'(cnt_q);
          state_d = S_CNT;
        end
      end
      S_CNT: begin
        if (accept_c) begin
          csum_d = checksum ^ BYTE_W'(cnt_q);
          if (rem_q != '0) begin
            rd_en_d    = 1'b1;
            mem_addr_d = addr_q;
            state_d    = S_RD;
          end else begin
            tx_load = 1'b1;
            tx_byte = csum_d;
            state_d = S_SUM;
          end
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        word_d  = mem_rd_data;
        tx_load = 1'b1;
        tx_byte = mem_rd_data[DATA_WIDTH-1 -: BYTE_W];
        state_d = S_HI;
      end
      S_HI: begin
        if (accept_c) begin
          csum_d  = checksum ^ word_q[DATA_WIDTH-1 -: BYTE_W];
          tx_load = 1'b1;
          tx_byte = word_q[BYTE_W-1:0];
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (accept_c) begin
          csum_d = checksum ^ word_q[BYTE_W-1:0];
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - ADDR_WIDTH'(1);
          if (rem_d != '0) begin
            rd_en_d    = 1'b1;
            mem_addr_d = addr_d;
            state_d    = S_RD;
          end else begin
            tx_load = 1'b1;
            tx_byte = csum_d;
            state_d = S_SUM;
          end
        end
      end
      S_SUM: begin
        if (accept_c) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dsp_mem_dump.sv
// Directed bench for dsp_mem_dump: table-driven frames plus restart, backpressure and reset corners.
module tb_dsp_mem_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  word_count;
  logic [7:0]  mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic [7:0]  checksum;

  dsp_mem_dump dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  // Capture transferred bytes, read addresses and done pulses.
  logic [7:0] got[$];
  logic [7:0] rd_addrs[$];
  int         done_cnt = 0;
  always @(posedge clk) begin
    if (tx_valid && tx_ready) got.push_back(tx_data);
    if (mem_rd_en) rd_addrs.push_back(mem_addr);
    if (done) done_cnt++;
  end

  typedef struct {
    logic [7:0]       base;
    logic [7:0]       cnt;
    bit               rand_ready;
    int               nbytes;
    logic [0:11][7:0] exp_bytes;
    logic [0:2][7:0]  exp_addr;
    logic [7:0]       exp_sum;
  } vec_t;

  vec_t vecs[5];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input int inject_k, input bit start_at_done);
    int k;
    int b0, r0, d0;
    logic       pv, pr;
    logic [7:0] pd;
    b0 = got.size();
    r0 = rd_addrs.size();
    d0 = done_cnt;
    @(negedge clk);
    base_addr  = v.base;
    word_count = v.cnt;
    start      = 1'b1;
    tx_ready   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("checksum_cleared", 32'(checksum), 32'd0);
    do begin
      if (v.rand_ready) tx_ready = 1'($urandom_range(0, 1));
      if (k == inject_k) begin
        start      = 1'b1;
        base_addr  = 8'h00;
        word_count = 8'h05;
      end else begin
        start = 1'b0;
      end
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
      @(negedge clk);
      k++;
      if (pv && !pr) begin
        check("stall_valid_held", 32'(tx_valid), 32'd1);
        check("stall_data_held", 32'(tx_data), 32'(pd));
      end
    end while (!done && k < 300);
    start = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    if (!v.rand_ready) check("done_latency", 32'(k), 32'(3 + 4 * int'(v.cnt)));
    check("busy_cleared", 32'(busy), 32'd0);
    check("final_checksum", 32'(checksum), 32'(v.exp_sum));
    if (start_at_done) start = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("byte_count", 32'(got.size() - b0), 32'(v.nbytes));
    for (int i = 0; i < v.nbytes; i++) begin
      if (b0 + i < got.size()) check("frame_byte", 32'(got[b0 + i]), 32'(v.exp_bytes[i]));
    end
    check("read_count", 32'(rd_addrs.size() - r0), 32'(v.cnt));
    for (int i = 0; i < int'(v.cnt) && i < 3; i++) begin
      if (r0 + i < rd_addrs.size()) check("read_addr", 32'(rd_addrs[r0 + i]), 32'(v.exp_addr[i]));
    end
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(tx_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{base: 8'h10, cnt: 8'd3, rand_ready: 1'b0, nbytes: 9,
                exp_bytes: {8'hA5, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hBC, 24'h0},
                exp_addr: {8'h10, 8'h11, 8'h12}, exp_sum: 8'hBC};
    vecs[1] = '{base: 8'h10, cnt: 8'd0, rand_ready: 1'b0, nbytes: 3,
                exp_bytes: {8'hA5, 8'h00, 8'h00, 72'h0},
                exp_addr: 24'h0, exp_sum: 8'h00};
    vecs[2] = '{base: 8'hFE, cnt: 8'd3, rand_ready: 1'b0, nbytes: 9,
                exp_bytes: {8'hA5, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h03, 24'h0},
                exp_addr: {8'hFE, 8'hFF, 8'h00}, exp_sum: 8'h03};
    vecs[3] = vecs[0];
    vecs[3].rand_ready = 1'b1;
    vecs[4] = '{base: 8'h11, cnt: 8'd1, rand_ready: 1'b0, nbytes: 5,
                exp_bytes: {8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h67, 56'h0},
                exp_addr: {8'h11, 16'h0}, exp_sum: 8'h67};

    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h10] = 16'h1234;
    mem[8'h11] = 16'hABCD;
    mem[8'h12] = 16'h00FF;
    mem[8'hFE] = 16'h0001;
    mem[8'hFF] = 16'h0002;
    mem[8'h00] = 16'h0003;

    reset      = 1'b0;
    start      = 1'b0;
    base_addr  = 8'h00;
    word_count = 8'h00;
    tx_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_frame(vecs[i], -1, 1'b0);

    // Start pulsed mid-frame must not disturb the frame in flight.
    run_frame(vecs[0], 5, 1'b0);
    // Start coincident with the cycle after done is ignored.
    run_frame(vecs[2], -1, 1'b1);

    // Reset during the low-byte phase of the first word.
    @(negedge clk);
    base_addr  = 8'h10;
    word_count = 8'd3;
    start      = 1'b1;
    tx_ready   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_lo_byte", 32'(tx_data), 32'h34);
    #2 reset = 1'b0;
    #1;
    check("async_mem_addr", 32'(mem_addr), 32'd0);
    check("async_rd_en", 32'(mem_rd_en), 32'd0);
    check("async_tx_data", 32'(tx_data), 32'd0);
    check("async_tx_valid", 32'(tx_valid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_checksum", 32'(checksum), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_frame(vecs[0], -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
